pipe_stage_reg: RTL and testbench

Generic parametrised valid/ready pipeline register, the successor to the fixed-field IF/ID/EX stage registers. It carries an opaque DATA_W payload; the decoder packs and unpacks fields outside the block. Supports flush, stall and kill (bubble insert), plus a saturating starvation counter for performance analysis. It is instantiated between every core pipeline stage (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 52 +++++
 rtl/pipe_stage_reg_sat_counter.sv | 37 +++
 rtl/pipe_stage_reg.sv | 191 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
//   Shared definitions for the generic valid/ready pipeline stage register:
//   - PIPE_BUBBLE: all-zero payload. Stages slice it to their DATA_W.
//   - `PIPE_SAT_INC(val, w): saturating increment of a w-bit value.
//   - Field offsets used by the decoder to pack and unpack the ID/EX and
//     EX/MEM payloads that travel through pipe_stage_reg.
//   - main_act_e: the next-state action for the main entry.
`ifndef PIPE_STAGE_REG_PKG_SV
`define PIPE_STAGE_REG_PKG_SV

// Holds at all-ones instead of wrapping back to zero.
`define PIPE_SAT_INC(val, w) (((val) == {(w){1'b1}}) ? (val) : ((val) + (w)'(1)))

package pipe_stage_reg_pkg;

  // Widest payload any stage carries. Each stage slices its own width.
  localparam int unsigned PIPE_MAX_DATA_W = 256;
  localparam logic [PIPE_MAX_DATA_W-1:0] PIPE_BUBBLE = '0;

  // ID/EX payload layout (LSB offset and width of each field).
  localparam int unsigned IDEX_PC_LSB   = 0;
  localparam int unsigned IDEX_PC_W     = 32;
  localparam int unsigned IDEX_RS1_LSB  = IDEX_PC_LSB + IDEX_PC_W;
  localparam int unsigned IDEX_RS1_W    = 5;
  localparam int unsigned IDEX_RS2_LSB  = IDEX_RS1_LSB + IDEX_RS1_W;
  localparam int unsigned IDEX_RS2_W    = 5;
  localparam int unsigned IDEX_RD_LSB   = IDEX_RS2_LSB + IDEX_RS2_W;
  localparam int unsigned IDEX_RD_W     = 5;
  localparam int unsigned IDEX_IMM_LSB  = IDEX_RD_LSB + IDEX_RD_W;
  localparam int unsigned IDEX_IMM_W    = 17;
  localparam int unsigned IDEX_DATA_W   = IDEX_IMM_LSB + IDEX_IMM_W;

  // EX/MEM payload layout.
  localparam int unsigned EXMEM_ALU_LSB = 0;
  localparam int unsigned EXMEM_ALU_W   = 32;
  localparam int unsigned EXMEM_RD_LSB  = EXMEM_ALU_LSB + EXMEM_ALU_W;
  localparam int unsigned EXMEM_RD_W    = 5;
  localparam int unsigned EXMEM_MEM_LSB = EXMEM_RD_LSB + EXMEM_RD_W;
  localparam int unsigned EXMEM_MEM_W   = 3;
  localparam int unsigned EXMEM_DATA_W  = EXMEM_MEM_LSB + EXMEM_MEM_W;

  // What the main entry does on the next clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_DRAIN = 2'd3
  } main_act_e;

endpackage

`endif

// File: rtl/pipe_stage_reg_sat_counter.sv
// pipe_sat_counter
//   CNT_W-bit up counter that saturates at all-ones and never wraps.
//   Ports:
//     clock   - rising-edge clock
//     reset_n - asynchronous active-low reset, clears the count
//     inc     - increment enable for this cycle
//     count   - current count (register output)
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = `PIPE_SAT_INC(count_q, CNT_W);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic valid/ready pipeline register with flush, stall and kill, plus a
//   saturating starvation counter. Carries an opaque DATA_W payload.
//   Optional skid entry enabled by defining YSYX_22040931_PIPE_SKID_EN; this
//   makes in_ready a registered signal (no path from out_ready/stall).
//   Ports:
//     clock, reset_n        - rising-edge clock, async active-low reset
//     flush                 - drop held and incoming beats this cycle
//     stall                 - hold the stage, block the output transfer
//     kill                  - accepted incoming beat becomes a bubble
//     in_valid/in_ready/in_data    - upstream handshake and payload
//     out_valid/out_ready/out_data - downstream handshake and payload
//     occupancy             - beats currently held (0..1, or 0..2 with skid)
//     bubble_cnt            - saturating count of starved output cycles
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned CLEAR_ON_BUBBLE = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              kill,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit                CLEAR       = (CLEAR_ON_BUBBLE != 0);
  localparam logic [DATA_W-1:0] BUBBLE_DATA = PIPE_BUBBLE[DATA_W-1:0];

  logic              main_v_q;
  logic              main_v_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;

  logic              fire_in;
  logic              fire_out;
  logic              in_ready_w;
  logic [DATA_W-1:0] in_payload;
  logic [DATA_W-1:0] main_empty_data;
  logic              bubble_inc;

  assign fire_out = main_v_q & out_ready & ~stall;
  assign fire_in  = in_valid & in_ready_w & ~flush;

  // Payload written for an incoming beat; a killed beat is a bubble.
  assign in_payload      = (kill && CLEAR) ? BUBBLE_DATA : in_data;
  assign main_empty_data = CLEAR ? BUBBLE_DATA : main_data_q;

`ifdef YSYX_22040931_PIPE_SKID_EN

  logic              skid_v_q;
  logic              skid_v_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic [DATA_W-1:0] skid_empty_data;

  assign skid_empty_data = CLEAR ? BUBBLE_DATA : skid_data_q;

  // Ready depends only on skid occupancy: while skid is free a beat can
  // always land somewhere, whatever the downstream does this cycle.
  assign in_ready_w = ~skid_v_q | flush;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_data_d = main_empty_data;
      skid_v_d    = 1'b0;
      skid_data_d = skid_empty_data;
    end else if (fire_out) begin
      if (skid_v_q) begin
        // Skid is older than anything arriving now, so it moves up first.
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        if (fire_in) begin
          skid_v_d    = ~kill;
          skid_data_d = in_payload;
        end else begin
          skid_v_d    = 1'b0;
          skid_data_d = skid_empty_data;
        end
      end else if (fire_in) begin
        main_v_d    = ~kill;
        main_data_d = in_payload;
      end else begin
        main_v_d    = 1'b0;
        main_data_d = main_empty_data;
      end
    end else if (fire_in) begin
      if (!main_v_q) begin
        main_v_d    = ~kill;
        main_data_d = in_payload;
      end else begin
        skid_v_d    = ~kill;
        skid_data_d = in_payload;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign occupancy = 2'(main_v_q) + 2'(skid_v_q);

`else

  main_act_e main_act;

  assign in_ready_w = ~main_v_q | (out_ready & ~stall) | flush;

  always_comb begin
    main_act = ACT_HOLD;
    if (flush) begin
      main_act = ACT_FLUSH;
    end else if (fire_in) begin
      main_act = ACT_LOAD;
    end else if (fire_out) begin
      main_act = ACT_DRAIN;
    end
  end

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    case (main_act)
      ACT_FLUSH, ACT_DRAIN: begin
        main_v_d    = 1'b0;
        main_data_d = main_empty_data;
      end
      ACT_LOAD: begin
        main_v_d    = ~kill;
        main_data_d = in_payload;
      end
      default: begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
      end
    endcase
  end

  assign occupancy = {1'b0, main_v_q};

`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
    end
  end

  // Starved: downstream would take a beat but there is none to give.
  assign bubble_inc = out_ready & ~stall & ~main_v_q & ~flush;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (bubble_inc),
    .count   (bubble_cnt)
  );

  assign in_ready  = in_ready_w;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned DW = 64;
  localparam int          CNT_MAX = 65535;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0, stall = 1'b0, kill = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;

  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [1:0]    occupancy2;
  logic [1:0]    bubble_cnt2;

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(16), .CLEAR_ON_BUBBLE(1)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .stall(stall), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(2), .CLEAR_ON_BUBBLE(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .stall(stall), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the stage as a FIFO of beats with a capacity of 1
  // (base) or 2 (skid), plus an integer starvation count.
  logic [DW-1:0] mq[$];
  int            mcnt;
  logic          m_rdy;
  logic          rdy_seen;
`ifdef YSYX_22040931_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  task automatic model_step(input logic iv, fl, st, kl, orr, input logic [DW-1:0] d);
    bit can_out, fin, fout;
    can_out = orr && !st;
    if (SKID) m_rdy = (mq.size() < 2) || fl;
    else      m_rdy = (mq.size() == 0) || can_out || fl;
    fout = (mq.size() > 0) && can_out;
    fin  = iv && m_rdy && !fl;
    if (can_out && mq.size() == 0 && !fl && mcnt < CNT_MAX) mcnt++;
    if (fl) mq.delete();
    else begin
      if (fout) void'(mq.pop_front());
      if (fin && !kl) mq.push_back(d);
    end
  endtask

  // Drive one cycle starting at a negedge; returns at the next negedge.
  task automatic cyc(input logic iv, fl, st, kl, orr, input logic [DW-1:0] d);
    in_valid = iv; flush = fl; stall = st; kill = kl; out_ready = orr; in_data = d;
    #1;
    rdy_seen = in_ready;
    model_step(iv, fl, st, kl, orr, d);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; stall = 1'b0; kill = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_out_valid", DW'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_occupancy", DW'(occupancy), '0);
    chk("reset_bubble_cnt", DW'(bubble_cnt), '0);
    #2;
    reset_n = 1'b1;
    mq.delete();
    mcnt = 0;
    @(negedge clock);
  endtask

  typedef struct {
    logic          iv, fl, st, kl, orr;
    logic [DW-1:0] d;
    logic          e_rdy, e_v;
    logic [DW-1:0] e_d;
    logic [1:0]    e_occ;
  } vec_t;

  function automatic vec_t mk(input logic iv, fl, st, kl, orr, input logic [DW-1:0] d,
                              input logic e_rdy, e_v, input logic [DW-1:0] e_d,
                              input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.fl = fl; v.st = st; v.kl = kl; v.orr = orr; v.d = d;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d; v.e_occ = e_occ;
    return v;
  endfunction

  initial begin
    vec_t tbl[19];
    logic [1:0] sat_exp[6];

    //            iv fl st kl orr data   rdy v  out    occ
    tbl[0]  = mk(1, 0, 0, 0, 1, 'h11,  1, 1, 'h11,  1);  // stream
    tbl[1]  = mk(1, 0, 0, 0, 1, 'h22,  1, 1, 'h22,  1);
    tbl[2]  = mk(1, 0, 0, 0, 1, 'h33,  1, 1, 'h33,  1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 'h00,  1, 0, 'h00,  0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 'hAB,  1, 1, 'hAB,  1);  // stall hold
    tbl[5]  = mk(1, 0, 1, 0, 1, 'hCD,  0, 1, 'hAB,  1);
    tbl[6]  = mk(1, 0, 1, 0, 1, 'hCD,  0, 1, 'hAB,  1);
    tbl[7]  = mk(1, 0, 1, 0, 1, 'hCD,  0, 1, 'hAB,  1);
    tbl[8]  = mk(0, 0, 0, 0, 1, 'h00,  1, 0, 'h00,  0);
    tbl[9]  = mk(1, 0, 0, 1, 1, 'h55,  1, 0, 'h00,  0);  // kill
    tbl[10] = mk(1, 0, 0, 0, 1, 'h66,  1, 1, 'h66,  1);
    tbl[11] = mk(0, 0, 0, 0, 1, 'h00,  1, 0, 'h00,  0);
    tbl[12] = mk(1, 0, 0, 0, 0, 'h77,  1, 1, 'h77,  1);  // flush while full
    tbl[13] = mk(1, 1, 0, 0, 0, 'h88,  1, 0, 'h00,  0);
    tbl[14] = mk(0, 0, 0, 0, 0, 'h00,  1, 0, 'h00,  0);
    tbl[15] = mk(1, 0, 1, 0, 1, 'h99,  1, 1, 'h99,  1);  // stall, empty accepts
    tbl[16] = mk(0, 0, 0, 0, 0, 'h00,  0, 1, 'h99,  1);
    tbl[17] = mk(1, 0, 0, 0, 1, 'hAA,  1, 1, 'hAA,  1);  // pass-through replace
    tbl[18] = mk(0, 0, 0, 0, 1, 'h00,  1, 0, 'h00,  0);
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    mcnt = 0;
    @(negedge clock);
    do_reset();

`ifdef YSYX_22040931_PIPE_SKID_EN
    // Skid: fill both entries with downstream blocked, then release.
    cyc(1, 0, 0, 0, 0, 'h01);
    chk("skid_occ1", DW'(occupancy), 1);
    cyc(1, 0, 0, 0, 0, 'h02);
    chk("skid_occ2", DW'(occupancy), 2);
    chk("skid_out_first", out_data, 'h01);
    in_valid = 1'b0; #1;
    chk("skid_full_ready", DW'(in_ready), 0);
    @(negedge clock);
    cyc(0, 0, 0, 0, 1, 'h00);
    chk("skid_ready_in_fire", DW'(rdy_seen), 0);
    chk("skid_out_second", out_data, 'h02);
    chk("skid_out_valid2", DW'(out_valid), 1);
    cyc(0, 0, 0, 0, 1, 'h00);
    chk("skid_ready_after", DW'(rdy_seen), 1);
    chk("skid_drained", DW'(out_valid), 0);
`else
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].iv, tbl[i].fl, tbl[i].st, tbl[i].kl, tbl[i].orr, tbl[i].d);
      chk($sformatf("vec%0d_in_ready", i), DW'(rdy_seen), DW'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].e_v));
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_d);
      chk($sformatf("vec%0d_occupancy", i), DW'(occupancy), DW'(tbl[i].e_occ));
      if (i == 2) chk("stream_bubble_cnt", DW'(bubble_cnt), 1);
    end
`endif

    // Saturation: 2-bit counter sticks at 3, 16-bit counter keeps counting.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 1, 'h00);
      chk($sformatf("sat2_cycle%0d", i), DW'(bubble_cnt2), DW'(sat_exp[i]));
      chk($sformatf("cnt16_cycle%0d", i), DW'(bubble_cnt), DW'(i + 1));
    end

    // Randomised run against the FIFO model, with one mid-stream reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic          r_iv, r_fl, r_st, r_kl, r_orr;
      logic [DW-1:0] r_d;
      if (i == 1500) do_reset();
      r_iv  = ($urandom_range(0, 3) != 0);
      r_fl  = ($urandom_range(0, 15) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_kl  = ($urandom_range(0, 7) == 0);
      r_orr = ($urandom_range(0, 3) != 0);
      r_d   = {$urandom, $urandom};
      cyc(r_iv, r_fl, r_st, r_kl, r_orr, r_d);
      chk("rnd_in_ready", DW'(rdy_seen), DW'(m_rdy));
      chk("rnd_out_valid", DW'(out_valid), DW'(mq.size() > 0));
      chk("rnd_out_data", out_data, (mq.size() > 0) ? mq[0] : '0);
      chk("rnd_occupancy", DW'(occupancy), DW'(mq.size()));
      chk("rnd_bubble_cnt", DW'(bubble_cnt), DW'(mcnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
